// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - bin, LSB first, through one full-subtractor slice and a borrow flop.
// Defining SERIAL_SUB_OVF_EN adds the two's-complement overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_brw, r_last, r_bout;
  logic             w_d, w_brw, w_accept, w_shift, w_fin;
  assign w_d      = r_a[0] ^ r_b[0] ^ r_brw;
  assign w_brw    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
  assign w_accept = (r_state == IDLE) && start;
  // r_last marks the settle cycle after the final bit, so DONE lands WIDTH+1 edges after accept
  assign w_shift  = (r_state == SHIFT) && !r_last;
  assign w_fin    = (r_state == SHIFT) && r_last;
  assign diff     = r_diff;
  assign bout     = r_bout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE)  ? (start ? SHIFT : IDLE) :
             (r_state == SHIFT) ? (r_last ? DONE : SHIFT) : IDLE;
  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_brw  <= 1'b0;
      r_bout <= 1'b0;
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_brw  <= bin;
      r_res  <= '0;
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (w_shift) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_res  <= {w_d, r_res[WIDTH-1:1]};
      r_brw  <= w_brw;
      r_last <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? r_cnt : r_cnt + CW'(1);
    end else if (w_fin) begin
      r_diff <= r_res;
      r_bout <= r_brw;
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  logic r_amsb, r_bmsb, r_ovf;
  assign ovf = r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_amsb <= a[WIDTH-1];
      r_bmsb <= b[WIDTH-1];
    end else if (w_fin) begin
      r_ovf  <= (r_amsb ^ r_bmsb) & (r_res[WIDTH-1] ^ r_amsb);
    end
  end
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random operations against an integer-arithmetic reference.
module tb_serial_subtractor;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif
  int compared = 0;
  int mismatched = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation; inj>0 pulses start for the single edge N+inj after the accept edge N.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin, input int inj);
    int e, se, n_done, lat;
    logic [W-1:0] exp_diff;
    logic exp_bout, exp_ovf;
    e        = int'(ta) - int'(tb_) - int'(tbin);
    exp_bout = (e < 0);
    exp_diff = W'(e);
    se       = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
    exp_ovf  = (se < -(2 ** (W - 1))) || (se > 2 ** (W - 1) - 1);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    n_done = 0;
    lat = 0;
    for (int k = 1; k <= W + 6; k++) begin
      if (k == inj) begin
        start = 1'b1; a = '1; b = W'(1);
      end else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          lat = k;
          check("diff", 32'(diff), 32'(exp_diff));
          check("bout", 32'(bout), 32'(exp_bout));
          check("busy_in_done", 32'(busy), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
          check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
        end
      end
    end
    start = 1'b0;
    check("done_count", 32'(n_done), 32'd1);
    check("latency", 32'(lat), 32'(W + 1));
    check("busy_idle_after", 32'(busy), 32'd0);
    check("diff_held", 32'(diff), 32'(exp_diff));
    check("bout_held", 32'(bout), 32'(exp_bout));
  endtask

  task automatic idle_no_done(input int n);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    check("idle_quiet", 32'(cnt), 32'd0);
  endtask

  initial begin
    #12 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_no_done(20);

    op(8'h5A, 8'h23, 1'b0, 0);
    op(8'h10, 8'h20, 1'b1, 0);
    op(8'h00, 8'h00, 1'b1, 0);
    op(8'h05, 8'h03, 1'b0, 3);
    op(8'hC4, 8'h11, 1'b0, 0);
    op(8'h33, 8'h34, 1'b0, W + 2);
    op(8'h80, 8'h01, 1'b0, 0);
    op(8'h7F, 8'hFF, 1'b0, 0);
    op(8'hFF, 8'hFF, 1'b0, 0);
    op(8'hFF, 8'h7F, 1'b1, 0);

    // reset four cycles into SHIFT: everything clears at once, no done follows
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    idle_no_done(20);
    op(8'h80, 8'h01, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), (i % 4 == 0) ? int'($urandom_range(1, W + 2)) : 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial full subtractor. It is the inverse-operation companion to the team's combinational full-adder cell.
- Computes A - B - bin LSB-first, one bit per clock, through a single full-subtractor slice and a borrow flip-flop.
- Used as a small sequential benchmark circuit for netlist fault simulation and test generation.
- Operands load in parallel; the result is presented in parallel with a done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse; result valid from this cycle
- diff  output  WIDTH  difference (A - B - bin) mod 2^WIDTH
- bout  output  1  final borrow-out (1 when A < B + bin, unsigned)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift registers, borrow flop and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: when start=1 at a clock edge:
  - capture a, b into shift registers and bin into the borrow flop;
  - clear the counter; go to SHIFT.
  - start=0 keeps the FSM in IDLE.
- SHIFT: each cycle:
  - d = a_sr[0] ^ b_sr[0] ^ brw
  - brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw)
  - shift a_sr and b_sr right by 1; shift d into the MSB of the result register (right shift).
  - counter increments. After the WIDTH-th bit (counter == WIDTH-1), go to DONE.
- DONE (one cycle):
  - done=1; diff=result register; bout=final brw.
  - Unconditionally return to IDLE next cycle.
- Latency: accepted start at edge N puts the FSM in DONE at edge N+WIDTH+1, so done is high for the cycle after that edge. Total WIDTH+1 cycles from accept to done.
- diff and bout hold their values after DONE until the next accepted start's DONE. They do not glitch or clear during SHIFT; the result register is internal until DONE.
- start while busy=1: ignored. No queuing, no effect on the operation in progress.
- start asserted in the DONE cycle: ignored. It must be re-asserted in IDLE.
- a, b, bin changing during SHIFT: no effect; they are sampled only at accept.
- Reset mid-operation: immediate abort. All outputs return to reset values; no done pulse is produced.
- Wrap-around: the counter width is clog2(WIDTH). The counter never exceeds WIDTH-1.
- Pure unsigned arithmetic; no signed interpretation unless the optional feature is enabled.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined, add output port ovf (1 bit, reset 0), valid with done and held like diff.
  - ovf = 1 when the two's-complement subtraction overflows.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operand MSBs.
  - A capture register holds those MSBs.
- When not defined: no ovf port and no extra flops. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n=0 mid-cycle -> busy=0, done=0, diff=0x00, bout=0 immediately. No done pulse with start=0 for 20 cycles.
- Basic subtraction: WIDTH=8, a=0x5A, b=0x23, bin=0, start pulse -> done high exactly 9 cycles after the accept edge; diff=0x37, bout=0.
- Borrow out: a=0x10, b=0x20, bin=1 -> diff=0xEF, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Start while busy: second start with a=0xFF, b=0x01 issued 3 cycles into an operation on a=0x05, b=0x03 -> one done only; diff=0x02, bout=0. The next start in IDLE is then accepted normally.
- Reset mid-operation: assert rst_n=0 at cycle 4 of SHIFT -> outputs zero at once, no done pulse. A fresh a=0x80, b=0x01 then yields diff=0x7F, bout=0.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> ovf=1. a=0x7F, b=0xFF -> diff=0x80, ovf=1. a=0x05, b=0x03 -> ovf=0.
